// File: rtl/dual_slot_arbiter_if.sv
// Bus between the dual-slot arbiter and its requesters.
//   req   : 12-bit request vector, bit i = requester i wants a slot
//   rel_a : release strobe for slot A
//   rel_b : release strobe for slot B
//   gnt_a : slot A owner, encoded index+1 (0 = idle)
//   gnt_b : slot B owner, encoded index+1 (0 = idle)
//   tmo_a : one-cycle pulse, slot A force-released by hold timeout
//   tmo_b : one-cycle pulse, slot B force-released by hold timeout
interface dual_slot_arbiter_if;
  logic [11:0] req;
  logic        rel_a;
  logic        rel_b;
  logic [3:0]  gnt_a;
  logic [3:0]  gnt_b;
  logic        tmo_a;
  logic        tmo_b;

  modport slave  (input  req, rel_a, rel_b, output gnt_a, gnt_b, tmo_a, tmo_b);
  modport master (output req, rel_a, rel_b, input  gnt_a, gnt_b, tmo_a, tmo_b);
endinterface

// File: rtl/dual_slot_arbiter.sv
// Dual-slot arbiter: 12 requesters share two slots (A, B). Each slot is an
// independent IDLE/BUSY FSM with a hold counter that force-releases the
// owner after MAX_HOLD cycles. Idle slots are filled from a rotating
// descending search that starts at ptr.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : dual_slot_arbiter_if.slave (req/rel in, gnt/tmo out)
// Parameter:
//   MAX_HOLD : max cycles a slot stays granted (2..255)

module dsa_slot #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_take,
  input  logic [3:0]  i_idx,
  input  logic [11:0] i_req,
  input  logic        i_rel,
  output logic        o_busy,
  output logic [3:0]  o_owner,
  output logic [3:0]  o_gnt,
  output logic        o_tmo
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_owner;
  logic [7:0]  r_cnt;
  logic        r_tmo;
  logic        w_drop, w_hit, w_release;

  assign w_drop    = ~i_req[r_owner];
  assign w_hit     = (r_cnt == HOLD_LAST);
  assign w_release = (r_state == S_BUSY) & (i_rel | w_drop | w_hit);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_take)    w_state_nxt = S_BUSY;
      S_BUSY: if (w_release) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Owner/counter/timeout datapath. tmo only flags a release caused purely
  // by the hold counter; an explicit release or a dropped req wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= w_release & w_hit & ~i_rel & ~w_drop;
      if (r_state == S_IDLE) begin
        if (i_take) begin
          r_owner <= i_idx;
          r_cnt   <= '0;
        end
      end else begin
        r_cnt <= w_release ? 8'd0 : r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    o_busy  = (r_state == S_BUSY);
    o_owner = r_owner;
    o_gnt   = (r_state == S_BUSY) ? r_owner + 4'd1 : 4'd0;
    o_tmo   = r_tmo;
  end
endmodule

module dual_slot_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dual_slot_arbiter_if.slave   bus
);
  logic [1:0]       w_busy, w_take, w_rel, w_tmo;
  logic [1:0][3:0]  w_owner, w_gnt, w_idx;
  logic [11:0]      w_owned, w_elig, w_elig_b;
  logic [4:0]       w_pick_a, w_pick_b;
  logic [3:0]       r_ptr;

  // First set bit of m scanning p, p-1, ..., 0, 11, ..., p+1.
  // Returns {found, index}.
  function automatic logic [4:0] find_first(input logic [11:0] m, input logic [3:0] p);
    logic [4:0] r;
    int         j;
    r = '0;
    for (int k = 0; k < 12; k++) begin
      j = int'(p) - k;
      if (j < 0) j = j + 12;
      if (!r[4] && m[j]) r = {1'b1, 4'(j)};
    end
    return r;
  endfunction

  function automatic logic [3:0] dec_wrap(input logic [3:0] i);
    return (i == 4'd0) ? 4'd11 : i - 4'd1;
  endfunction

  // Slot B searches after slot A's same-cycle pick is removed, so B always
  // lands later in search order than A and no requester owns both slots.
  always_comb begin
    w_owned = '0;
    for (int s = 0; s < 2; s++)
      if (w_busy[s]) w_owned[w_owner[s]] = 1'b1;
    w_elig   = bus.req & ~w_owned;
    w_pick_a = find_first(w_elig, r_ptr);
    w_take   = '0;
    w_take[0] = ~w_busy[0] & w_pick_a[4];
    w_elig_b = w_elig;
    if (w_take[0]) w_elig_b[w_pick_a[3:0]] = 1'b0;
    w_pick_b = find_first(w_elig_b, r_ptr);
    w_take[1] = ~w_busy[1] & w_pick_b[4];
    w_idx[0] = w_pick_a[3:0];
    w_idx[1] = w_pick_b[3:0];
  end

  assign w_rel[0] = bus.rel_a;
  assign w_rel[1] = bus.rel_b;

  // Pointer lands one below the last requester granted this cycle.
  always_ff @(posedge clk) begin
    if (reset)          r_ptr <= 4'd11;
    else if (w_take[1]) r_ptr <= dec_wrap(w_idx[1]);
    else if (w_take[0]) r_ptr <= dec_wrap(w_idx[0]);
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    dsa_slot #(.MAX_HOLD(MAX_HOLD)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_take  (w_take[g]),
      .i_idx   (w_idx[g]),
      .i_req   (bus.req),
      .i_rel   (w_rel[g]),
      .o_busy  (w_busy[g]),
      .o_owner (w_owner[g]),
      .o_gnt   (w_gnt[g]),
      .o_tmo   (w_tmo[g])
    );
  end

  assign bus.gnt_a = w_gnt[0];
  assign bus.gnt_b = w_gnt[1];
  assign bus.tmo_a = w_tmo[0];
  assign bus.tmo_b = w_tmo[1];
endmodule

// File: tb/tb_dual_slot_arbiter.sv
module tb_dual_slot_arbiter;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic reset;
  dual_slot_arbiter_if bus();

  dual_slot_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int ga; int gb; int ta; int tb2; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int obs_a, obs_b, obs_ta, obs_tb;

  // reference model state: owner index or -1 when idle
  int own[2] = '{-1, -1};
  int cnt[2] = '{0, 0};
  int tmo[2] = '{0, 0};
  int ptr = 11;

  task automatic chk(input string tag, input int a_val, input int e_val);
    n_chk++;
    if (a_val != e_val) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d @%0t", tag, a_val, e_val, $time);
    end
  endtask

  task automatic model(input logic [11:0] rq, input bit ra, input bit rb, input bit rs);
    int elig[$];
    int nown[2];
    int ncnt[2];
    int ntmo[2];
    int rel[2];
    int last;
    int idx;
    bit drop, to;
    if (rs) begin
      own = '{-1, -1}; cnt = '{0, 0}; tmo = '{0, 0}; ptr = 11;
      return;
    end
    rel[0] = ra; rel[1] = rb;
    for (int k = 0; k < 12; k++) begin
      idx = (ptr - k + 12) % 12;
      if (rq[idx] && idx != own[0] && idx != own[1]) elig.push_back(idx);
    end
    last = -1;
    for (int s = 0; s < 2; s++) begin
      ntmo[s] = 0;
      if (own[s] >= 0) begin
        drop = !rq[own[s]];
        to   = (cnt[s] == MH - 1);
        if (rel[s] != 0 || drop || to) begin
          ntmo[s] = (to && rel[s] == 0 && !drop) ? 1 : 0;
          nown[s] = -1; ncnt[s] = 0;
        end else begin
          nown[s] = own[s]; ncnt[s] = cnt[s] + 1;
        end
      end else if (elig.size() > 0) begin
        nown[s] = elig.pop_front(); ncnt[s] = 0; last = nown[s];
      end else begin
        nown[s] = -1; ncnt[s] = 0;
      end
    end
    if (last >= 0) ptr = (last + 11) % 12;
    own = nown; cnt = ncnt; tmo = ntmo;
  endtask

  task automatic step(input logic [11:0] rq, input bit ra, input bit rb, input bit rs);
    exp_t e;
    bus.req = rq; bus.rel_a = ra; bus.rel_b = rb; reset = rs;
    model(rq, ra, rb, rs);
    sb.push_back('{own[0] + 1, own[1] + 1, tmo[0], tmo[1]});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    obs_a = int'(bus.gnt_a); obs_b = int'(bus.gnt_b);
    obs_ta = int'(bus.tmo_a); obs_tb = int'(bus.tmo_b);
    chk("sb_gnt_a", obs_a, e.ga);
    chk("sb_gnt_b", obs_b, e.gb);
    chk("sb_tmo_a", obs_ta, e.ta);
    chk("sb_tmo_b", obs_tb, e.tb2);
  endtask

  logic [11:0] cur;
  int n;

  initial begin
    bus.req = '0; bus.rel_a = 1'b0; bus.rel_b = 1'b0; reset = 1'b1;
    @(negedge clk);
    step(12'h000, 0, 0, 1);
    step(12'h000, 0, 0, 1);
    chk("rst_gnt_a", obs_a, 0); chk("rst_gnt_b", obs_b, 0);
    chk("rst_tmo_a", obs_ta, 0); chk("rst_tmo_b", obs_tb, 0);

    // two top requesters from reset pointer
    step(12'hC00, 0, 0, 0);
    chk("pair_gnt_a", obs_a, 12); chk("pair_gnt_b", obs_b, 11);
    // release A with everyone requesting: idle one cycle, then rotation
    step(12'hFFF, 1, 0, 0);
    chk("rel_a_idle", obs_a, 0); chk("rel_a_keep_b", obs_b, 11);
    step(12'hFFF, 0, 0, 0);
    chk("rot_gnt_a", obs_a, 10);
    // reset while both busy
    step(12'hFFF, 0, 0, 1);
    chk("midrst_a", obs_a, 0); chk("midrst_b", obs_b, 0);
    chk("midrst_ta", obs_ta, 0); chk("midrst_tb", obs_tb, 0);
    step(12'hFFF, 0, 0, 0);
    chk("post_rst_a", obs_a, 12); chk("post_rst_b", obs_b, 11);
    // owner of B drops its request
    step(12'hBFF, 0, 0, 0);
    chk("drop_gnt_b", obs_b, 0); chk("drop_tmo_b", obs_tb, 0);
    chk("drop_keep_a", obs_a, 12);

    // single requester goes to A only, second lands in B
    step(12'h000, 0, 0, 1);
    step(12'h000, 1, 1, 0);
    chk("idle_rel_ign", obs_a, 0);
    step(12'h001, 0, 0, 0);
    chk("one_gnt_a", obs_a, 1); chk("one_gnt_b", obs_b, 0);
    step(12'h003, 0, 0, 0);
    chk("two_gnt_a", obs_a, 1); chk("two_gnt_b", obs_b, 2);

    // hold timeout on slot A owned by requester index 4
    step(12'h000, 0, 0, 1);
    step(12'h010, 0, 0, 0);
    chk("hold_gnt", obs_a, 5);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step(12'h010, 0, 0, 0);
      if (obs_a == 5) n++;
      else break;
    end
    chk("hold_len", n, MH);
    chk("tmo_a_pulse", obs_ta, 1);
    step(12'h010, 0, 0, 0);
    chk("tmo_a_clear", obs_ta, 0);
    chk("regrant_a", obs_a, 5);

    // randomized traffic against the model, sticky requests to reach timeouts
    cur = 12'h5A5;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) cur = 12'($urandom);
      step(cur, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
